// File: rtl/upipe_run_ctrl.sv
// rtl/upipe_run_ctrl.sv - fill/run/stop sequencer and token counter for a micropipeline ring
module upipe_run_ctrl #(
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 255,
    parameter int RST_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_tokens,
    input  logic [CNT_W-1:0] fill_tgt,
    input  logic             la,
    input  logic             rr,
    output logic             go_l,
    output logic             go_r,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] capacity,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] run_cycles
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HOLD = 3'd1;
    localparam logic [2:0] ST_FILL = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_STOP = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             la_s1, la_s2, la_d;
    logic             rr_s1, rr_s2, rr_d;
    logic             la_evt, rr_evt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] fill_lat;
    logic             timed_out;
    logic             accept, err_set, done_nxt, cap_inc, out_inc, tmr_evt;

    assign la_evt    = la_s2 & ~la_d;
    assign rr_evt    = rr_s2 & ~rr_d;
    assign timed_out = (timer == TMO_LAST);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        err_set   = 1'b0;
        done_nxt  = 1'b0;
        cap_inc   = 1'b0;
        out_inc   = 1'b0;
        tmr_evt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (n_tokens == '0) begin
                        err_set  = 1'b1;
                        done_nxt = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    err_set   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (timer == HOLD_LAST) begin
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                tmr_evt = la_evt;
                cap_inc = la_evt;
                if (abort) begin
                    err_set   = 1'b1;
                    state_nxt = ST_STOP;
                end else if (la_evt) begin
                    if (fill_lat != '0 && (capacity + CNT_ONE) == fill_lat)
                        state_nxt = ST_RUN;
                end else if (timed_out) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                tmr_evt = rr_evt;
                out_inc = rr_evt;
                if (abort) begin
                    err_set   = 1'b1;
                    state_nxt = ST_STOP;
                end else if (rr_evt) begin
                    if ((out_count + CNT_ONE) == n_lat)
                        state_nxt = ST_STOP;
                end else if (timed_out) begin
                    err_set   = 1'b1;
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // The pipeline is held in reset here; release the output only once rr has gone low.
                if (!rr_s2) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (timed_out) begin
                    err_set   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            la_s1      <= 1'b0;
            la_s2      <= 1'b0;
            la_d       <= 1'b0;
            rr_s1      <= 1'b0;
            rr_s2      <= 1'b0;
            rr_d       <= 1'b0;
            timer      <= '0;
            n_lat      <= '0;
            fill_lat   <= '0;
            go_l       <= 1'b0;
            go_r       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            capacity   <= '0;
            out_count  <= '0;
            run_cycles <= '0;
        end else begin
            state <= state_nxt;
            la_s1 <= la;
            la_s2 <= la_s1;
            la_d  <= la_s2;
            rr_s1 <= rr;
            rr_s2 <= rr_s1;
            rr_d  <= rr_s2;

            if (state == ST_IDLE || state_nxt != state || tmr_evt)
                timer <= '0;
            else
                timer <= timer + CNT_ONE;

            // Registered from next state so the asynchronous pipeline never sees decode glitches.
            go_l <= (state_nxt == ST_FILL) || (state_nxt == ST_RUN);
            go_r <= (state_nxt == ST_RUN) || ((state_nxt == ST_STOP) && go_r);
            busy <= (state_nxt != ST_IDLE);
            done <= done_nxt;

            if (accept) begin
                err        <= 1'b0;
                capacity   <= '0;
                out_count  <= '0;
                run_cycles <= '0;
                n_lat      <= n_tokens;
                fill_lat   <= fill_tgt;
            end else begin
                if (err_set)
                    err <= 1'b1;
                if (cap_inc)
                    capacity <= capacity + CNT_ONE;
                if (out_inc)
                    out_count <= out_count + CNT_ONE;
                if (state == ST_RUN && run_cycles != CNT_MAX)
                    run_cycles <= run_cycles + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_upipe_run_ctrl.sv
// tb/tb_upipe_run_ctrl.sv - directed self-checking bench for upipe_run_ctrl with a 4-deep pipeline model
module tb_upipe_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] n_tokens = '0;
    logic [15:0] fill_tgt = '0;
    logic        la = 1'b0;
    logic        rr = 1'b0;
    logic        go_l, go_r, busy, done, err;
    logic [15:0] capacity, out_count, run_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    upipe_run_ctrl #(.CNT_W(16), .TIMEOUT(255), .RST_HOLD(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .n_tokens   (n_tokens),
        .fill_tgt   (fill_tgt),
        .la         (la),
        .rr         (rr),
        .go_l       (go_l),
        .go_r       (go_r),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .capacity   (capacity),
        .out_count  (out_count),
        .run_cycles (run_cycles)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Four-stage pipeline model: go_l low empties it and forces la/rr low.
    int occ = 0;
    int l_t = 0;
    int r_t = 0;
    bit rr_block = 1'b0;

    always @(negedge clk) begin
        if (!go_l) begin
            occ = 0; l_t = 0; r_t = 0; la = 1'b0; rr = 1'b0;
        end else begin
            if (l_t > 0) begin
                l_t--;
                if (l_t == 2) la = 1'b0;
            end else if (occ < 4) begin
                la = 1'b1; occ++; l_t = 4;
            end
            if (r_t > 0) begin
                r_t--;
                if (r_t == 2) rr = 1'b0;
            end else if (go_r && !rr_block && occ > 0) begin
                rr = 1'b1; occ--; r_t = 4;
            end
        end
    end

    int   rr_low = 0;
    int   done_cnt = 0;
    int   gor_viol = 0;
    int   gol_high = 0;
    logic go_r_q = 1'b0;

    always @(posedge clk) rr_low <= rr ? 0 : rr_low + 1;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (go_l) gol_high++;
        if (go_r_q && !go_r && rr_low < 3) gor_viol++;
        go_r_q = go_r;
    end

    task automatic start_seq(input logic [15:0] n, input logic [15:0] f);
        @(negedge clk);
        n_tokens = n; fill_tgt = f; start = 1'b1; done_cnt = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_done"}, 32'(done), 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_run(input string tag, input int budget);
        int k = 0;
        while (go_r !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_run_seen"}, 32'(go_r), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_go_l", 32'(go_l), 0);
        check_eq("rst_go_r", 32'(go_r), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_capacity", 32'(capacity), 0);
        check_eq("rst_out_count", 32'(out_count), 0);
        check_eq("rst_run_cycles", 32'(run_cycles), 0);
        rst = 1'b0;

        // Fill until stall, drain 8
        start_seq(16'd8, 16'd0);
        wait_done("t1", 3000);
        check_eq("t1_capacity", 32'(capacity), 4);
        check_eq("t1_out_count", 32'(out_count), 8);
        check_eq("t1_err", 32'(err), 0);
        check_eq("t1_done_pulses", 32'(done_cnt), 1);
        check_eq("t1_go_r_order", 32'(gor_viol), 0);
        check_eq("t1_go_l", 32'(go_l), 0);
        check_eq("t1_go_r", 32'(go_r), 0);
        check_eq("t1_busy", 32'(busy), 0);

        // Fill target 2, drain 5
        start_seq(16'd5, 16'd2);
        wait_done("t2", 3000);
        check_eq("t2_capacity", 32'(capacity), 2);
        check_eq("t2_out_count", 32'(out_count), 5);
        check_eq("t2_run_nonzero", 32'(run_cycles != 16'd0), 1);
        check_eq("t2_err", 32'(err), 0);
        check_eq("t2_done_pulses", 32'(done_cnt), 1);

        // Output stalled in RUN
        rr_block = 1'b1;
        start_seq(16'd10, 16'd0);
        wait_done("t3", 3000);
        rr_block = 1'b0;
        check_eq("t3_err", 32'(err), 1);
        check_eq("t3_capacity", 32'(capacity), 4);
        check_eq("t3_out_count", 32'(out_count), 0);
        check_eq("t3_run_cycles", 32'(run_cycles), 255);
        check_eq("t3_go_l", 32'(go_l), 0);
        check_eq("t3_go_r", 32'(go_r), 0);
        check_eq("t3_done_pulses", 32'(done_cnt), 1);

        // Abort 3 cycles into RUN, then a clean single-token run
        gor_viol = 0;
        start_seq(16'd20, 16'd0);
        wait_run("t4", 3000);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("t4", 1000);
        check_eq("t4_err", 32'(err), 1);
        check_eq("t4_done_pulses", 32'(done_cnt), 1);
        check_eq("t4_go_r_order", 32'(gor_viol), 0);
        start_seq(16'd1, 16'd0);
        wait_done("t4b", 3000);
        check_eq("t4b_err", 32'(err), 0);
        check_eq("t4b_out_count", 32'(out_count), 1);

        // Zero-token start is refused and leaves counts alone
        gol_high = 0;
        start_seq(16'd0, 16'd0);
        wait_done("t5", 20);
        repeat (10) @(negedge clk);
        check_eq("t5_err", 32'(err), 1);
        check_eq("t5_busy", 32'(busy), 0);
        check_eq("t5_go_l_quiet", 32'(gol_high), 0);
        check_eq("t5_done_pulses", 32'(done_cnt), 1);
        check_eq("t5_out_count_held", 32'(out_count), 1);

        // Start during RUN is ignored
        start_seq(16'd6, 16'd0);
        wait_run("t5b", 3000);
        @(negedge clk);
        n_tokens = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5b", 3000);
        check_eq("t5b_out_count", 32'(out_count), 6);
        check_eq("t5b_err", 32'(err), 0);

        // Reset in the middle of FILL
        start_seq(16'd8, 16'd0);
        begin
            int k = 0;
            while (go_l !== 1'b1 && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("t6_go_l", 32'(go_l), 0);
        check_eq("t6_go_r", 32'(go_r), 0);
        check_eq("t6_busy", 32'(busy), 0);
        check_eq("t6_capacity", 32'(capacity), 0);
        check_eq("t6_out_count", 32'(out_count), 0);
        check_eq("t6_run_cycles", 32'(run_cycles), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
